// File: rtl/matmul_engine_module_if.sv
// Operand/scratchpad bus between the matrix engine and the register file block.
// Signal suffixes are from the engine's point of view.
interface matmul_engine_module_if #(
    parameter int BUS_WIDTH  = 64,
    parameter int ADDR_WIDTH = 32
);
    logic [BUS_WIDTH-1:0]  a_row_i;
    logic [BUS_WIDTH-1:0]  b_row_i;
    logic [BUS_WIDTH-1:0]  c_elem_i;
    logic [ADDR_WIDTH-1:0] address_a_o;
    logic [ADDR_WIDTH-1:0] address_b_o;
    logic [ADDR_WIDTH-1:0] address_c_o;
    logic                  sp_write_o;
    logic [BUS_WIDTH-1:0]  sp_data_o;

    modport master (
        input  a_row_i, b_row_i, c_elem_i,
        output address_a_o, address_b_o, address_c_o, sp_write_o, sp_data_o
    );

    modport slave (
        output a_row_i, b_row_i, c_elem_i,
        input  address_a_o, address_b_o, address_c_o, sp_write_o, sp_data_o
    );
endinterface

// File: rtl/matmul_engine_module.sv
// Matrix multiply engine: C = A*B or C += A*B, one signed MAC per cycle,
// writing each element back to the scratchpad with sticky per-element overflow flags.
module matmul_engine_module #(
    parameter int DATA_WIDTH = 32,
    parameter int BUS_WIDTH  = 64,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_bit_i,
    input  logic                 mode_bit_i,
    input  logic [1:0]           n_dim_i,
    input  logic [1:0]           k_dim_i,
    input  logic [1:0]           m_dim_i,
    matmul_engine_module_if.master bus,
    output logic [BUS_WIDTH-1:0] flags_o,
    output logic                 start_clear_o,
    output logic                 busy_o
);
    localparam int MAX_DIM    = BUS_WIDTH / DATA_WIDTH;
    localparam int IDX_W      = (MAX_DIM > 1) ? $clog2(MAX_DIM) : 1;
    localparam int CIDX_W     = 2 * IDX_W;
    localparam int ADDR_SHIFT = 5;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MAX_DIM - 1);

    typedef enum logic [2:0] {IDLE, INIT, MAC, WRITE, DONE} state_t;

    state_t state_q, state_d;

    logic [IDX_W-1:0]            i_q, j_q, k_q;
    logic [IDX_W-1:0]            n_last_q, k_last_q, m_last_q;
    logic                        mode_q;
    logic signed [BUS_WIDTH-1:0] acc_q;
    logic [BUS_WIDTH-1:0]        sp_data_q;
    logic [BUS_WIDTH-1:0]        flags_q;

    logic [CIDX_W-1:0]             c_idx;
    logic signed [DATA_WIDTH-1:0]  a_elem, b_elem;
    logic signed [2*DATA_WIDTH-1:0] product;
    logic signed [BUS_WIDTH-1:0]   product_ext, sum;
    logic                          add_ovf;

    // Dimension fields hold size-1; anything beyond the row capacity saturates.
    function automatic logic [IDX_W-1:0] clamp_dim(input logic [1:0] field);
        if (int'(field) > MAX_DIM - 1) return LAST_IDX;
        return IDX_W'(field);
    endfunction

    always_comb begin
        c_idx       = CIDX_W'(int'(i_q) * MAX_DIM + int'(j_q));
        a_elem      = DATA_WIDTH'(bus.a_row_i >> (int'(k_q) * DATA_WIDTH));
        b_elem      = DATA_WIDTH'(bus.b_row_i >> (int'(j_q) * DATA_WIDTH));
        product     = (2*DATA_WIDTH)'(a_elem) * (2*DATA_WIDTH)'(b_elem);
        product_ext = BUS_WIDTH'(product);
        sum         = acc_q + product_ext;
        add_ovf     = (acc_q[BUS_WIDTH-1] == product_ext[BUS_WIDTH-1]) &&
                      (sum[BUS_WIDTH-1] != acc_q[BUS_WIDTH-1]);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Bus outputs are decoded from the state so reset forces them to zero at once.
    always_comb begin
        state_d         = state_q;
        bus.address_a_o = '0;
        bus.address_b_o = '0;
        bus.address_c_o = '0;
        bus.sp_write_o  = 1'b0;
        bus.sp_data_o   = sp_data_q;
        start_clear_o   = 1'b0;
        busy_o          = (state_q != IDLE);
        case (state_q)
            IDLE: if (start_bit_i) state_d = INIT;
            INIT: begin
                bus.address_c_o = ADDR_WIDTH'(c_idx) << ADDR_SHIFT;
                state_d         = MAC;
            end
            MAC: begin
                bus.address_a_o = ADDR_WIDTH'(i_q) << ADDR_SHIFT;
                bus.address_b_o = ADDR_WIDTH'(k_q) << ADDR_SHIFT;
                if (k_q == k_last_q) state_d = WRITE;
            end
            WRITE: begin
                bus.address_c_o = ADDR_WIDTH'(c_idx) << ADDR_SHIFT;
                bus.sp_write_o  = 1'b1;
                bus.sp_data_o   = acc_q;
                if (i_q == n_last_q && j_q == m_last_q) state_d = DONE;
                else                                    state_d = INIT;
            end
            DONE: begin
                start_clear_o = 1'b1;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            i_q       <= '0;
            j_q       <= '0;
            k_q       <= '0;
            n_last_q  <= '0;
            k_last_q  <= '0;
            m_last_q  <= '0;
            mode_q    <= 1'b0;
            acc_q     <= '0;
            sp_data_q <= '0;
            flags_q   <= '0;
        end else begin
            case (state_q)
                IDLE: if (start_bit_i) begin
                    n_last_q <= clamp_dim(n_dim_i);
                    k_last_q <= clamp_dim(k_dim_i);
                    m_last_q <= clamp_dim(m_dim_i);
                    mode_q   <= mode_bit_i;
                    flags_q  <= '0;
                    i_q      <= '0;
                    j_q      <= '0;
                    k_q      <= '0;
                end
                INIT: begin
                    acc_q <= mode_q ? bus.c_elem_i : '0;
                    k_q   <= '0;
                end
                MAC: begin
                    acc_q <= sum;
                    k_q   <= k_q + 1'b1;
                    if (add_ovf) flags_q <= flags_q | (BUS_WIDTH'(1) << c_idx);
                end
                WRITE: begin
                    sp_data_q <= acc_q;
                    if (j_q == m_last_q) begin
                        j_q <= '0;
                        i_q <= i_q + 1'b1;
                    end else begin
                        j_q <= j_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign flags_o = flags_q;
endmodule
